// File: rtl/ped_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// ped_crossing_ctrl
//
// Pedestrian crossing controller placed downstream of the vehicle traffic
// light controller. It grants a timed WALK phase followed by a flashing
// DON'T WALK phase inside the vehicle red interval. One clock cycle is one
// second. Illegal (non one-hot) light inputs lock the block into a sticky
// FAULT state that only reset clears.
//
// Parameters
//   WALK_TIME   cycles of steady WALK
//   FLASH_TIME  cycles of flashing DON'T WALK
//   CNT_W       countdown width (WALK_TIME+FLASH_TIME must fit)
//
// Ports
//   clk          in   1 Hz system clock
//   n_reset      in   asynchronous active-low reset
//   red_in       in   vehicle red
//   yel_in       in   vehicle yellow
//   green_in     in   vehicle green
//   ped_btn      in   raw asynchronous pedestrian push-button
//   walk         out  WALK lamp
//   dont_walk    out  DON'T WALK lamp
//   ped_waiting  out  request latched but not yet served
//   countdown    out  seconds remaining in the crossing, 0 otherwise
//   fault        out  sticky light-input fault
// ---------------------------------------------------------------------------
module ped_crossing_ctrl #(
  parameter int WALK_TIME  = 20,
  parameter int FLASH_TIME = 8,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             red_in,
  input  logic             yel_in,
  input  logic             green_in,
  input  logic             ped_btn,
  output logic             walk,
  output logic             dont_walk,
  output logic             ped_waiting,
  output logic [CNT_W-1:0] countdown,
  output logic             fault
);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_WALK  = 2'd1;
  localparam logic [1:0] ST_FLASH = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_TOTAL  = CNT_W'(WALK_TIME + FLASH_TIME);
  localparam logic [CNT_W-1:0] CNT_FLASH1 = CNT_W'(FLASH_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             btn_meta_q, btn_sync_q, btn_prev_q;
  logic             red_q;
  logic [1:0]       state_q, state_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic             waiting_q, waiting_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic press;
  logic red_onset;
  logic one_hot;

  // The third button flop remembers the previous synchronized level, so a
  // press event is a single-cycle pulse on the synchronized rising edge.
  assign press     = btn_sync_q & ~btn_prev_q;
  assign red_onset = red_in & ~red_q;
  assign one_hot   = ( red_in & ~yel_in & ~green_in) |
                     (~red_in &  yel_in & ~green_in) |
                     (~red_in & ~yel_in &  green_in);

  // Button synchronizer, edge-detect history and red history.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      red_q      <= 1'b0;
    end else begin
      btn_meta_q <= ped_btn;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      red_q      <= red_in;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so every lamp and the countdown come straight from a flop. A fault on
  // the light inputs overrides every other transition.
  always_comb begin
    state_d     = state_q;
    walk_d      = walk_q;
    dont_walk_d = dont_walk_q;
    waiting_d   = waiting_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;

    if (!one_hot || state_q == ST_FAULT) begin
      state_d     = ST_FAULT;
      walk_d      = 1'b0;
      dont_walk_d = 1'b1;
      waiting_d   = 1'b0;
      cnt_d       = '0;
      fault_d     = 1'b1;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (red_onset && (waiting_q || press)) begin
            state_d     = ST_WALK;
            walk_d      = 1'b1;
            dont_walk_d = 1'b0;
            waiting_d   = 1'b0;
            cnt_d       = CNT_TOTAL;
          end else begin
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            waiting_d   = waiting_q | press;
            cnt_d       = '0;
          end
        end

        // Presses during WALK are deliberately dropped.
        ST_WALK: begin
          if (!red_in) begin
            state_d     = ST_STOP;
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_FLASH1) begin
              state_d     = ST_FLASH;
              walk_d      = 1'b0;
              dont_walk_d = 1'b1;
            end
          end
        end

        ST_FLASH: begin
          waiting_d = waiting_q | press;
          if (!red_in) begin
            state_d     = ST_STOP;
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d     = ST_STOP;
              dont_walk_d = 1'b1;
            end else begin
              dont_walk_d = ~dont_walk_q;
            end
          end
        end

        default: begin
          state_d     = ST_FAULT;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          waiting_d   = 1'b0;
          cnt_d       = '0;
          fault_d     = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_STOP;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      waiting_q   <= 1'b0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      waiting_q   <= waiting_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign ped_waiting = waiting_q;
  assign countdown   = cnt_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ped_crossing_ctrl
//
// Self-checking bench for ped_crossing_ctrl. A behavioural model tracks the
// crossing as "seconds elapsed since WALK began" and derives lamps and
// countdown arithmetically; the button path is modelled as a history of
// sampled button levels. Directed scenarios are followed by randomized
// traffic-light cycles with random button activity.
// ---------------------------------------------------------------------------
module tb_ped_crossing_ctrl;

  localparam int WT = 20;
  localparam int FT = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic          red_in = 1'b0;
  logic          yel_in = 1'b0;
  logic          green_in = 1'b1;
  logic          ped_btn = 1'b0;
  logic          walk;
  logic          dont_walk;
  logic          ped_waiting;
  logic [CW-1:0] countdown;
  logic          fault;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int mElapsed;
  bit mWaiting;
  bit mFault;
  bit mRedPrev;
  bit mHist[3];

  ped_crossing_ctrl #(
    .WALK_TIME (WT),
    .FLASH_TIME(FT),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .red_in     (red_in),
    .yel_in     (yel_in),
    .green_in   (green_in),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .ped_waiting(ped_waiting),
    .countdown  (countdown),
    .fault      (fault)
  );

  // 1 Hz clock scaled to a 10-unit period.
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mElapsed = -1;
    mWaiting = 1'b0;
    mFault   = 1'b0;
    mRedPrev = 1'b0;
    for (int i = 0; i < 3; i++) mHist[i] = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  // mHist[k] holds the button level sampled k+1 edges ago.
  task automatic modelStep(input bit r, input bit y, input bit g, input bit b);
    bit press, onset, illegal, inWalk;
    press   = mHist[1] & ~mHist[2];
    onset   = r & ~mRedPrev;
    illegal = (int'(r) + int'(y) + int'(g)) != 1;
    mHist[2] = mHist[1];
    mHist[1] = mHist[0];
    mHist[0] = b;
    mRedPrev = r;

    if (mFault || illegal) begin
      mFault   = 1'b1;
      mElapsed = -1;
      mWaiting = 1'b0;
    end else if (mElapsed < 0) begin
      if (onset && (mWaiting || press)) begin
        mElapsed = 0;
        mWaiting = 1'b0;
      end else begin
        mWaiting = mWaiting | press;
      end
    end else begin
      inWalk = mElapsed < WT;
      if (!inWalk) mWaiting = mWaiting | press;
      if (!r) mElapsed = -1;
      else begin
        mElapsed++;
        if (mElapsed >= WT + FT) mElapsed = -1;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    bit eWalk, eDw;
    int eCnt;
    if (mElapsed < 0) begin
      eWalk = 1'b0;
      eDw   = 1'b1;
      eCnt  = 0;
    end else begin
      eWalk = mElapsed < WT;
      eDw   = (mElapsed < WT) ? 1'b0 : (((mElapsed - WT) % 2) == 0);
      eCnt  = WT + FT - mElapsed;
    end
    checkOutput({tag, ".walk"},        32'(walk),        32'(eWalk));
    checkOutput({tag, ".dont_walk"},   32'(dont_walk),   32'(eDw));
    checkOutput({tag, ".ped_waiting"}, 32'(ped_waiting), 32'(mWaiting));
    checkOutput({tag, ".countdown"},   32'(countdown),   32'(eCnt));
    checkOutput({tag, ".fault"},       32'(fault),       32'(mFault));
  endtask

  // Drive one cycle of inputs, let the DUT clock them, then compare.
  task automatic applyStimulus(input string tag, input logic r, input logic y, input logic g, input logic b);
    red_in   = r;
    yel_in   = y;
    green_in = g;
    ped_btn  = b;
    @(posedge clk);
    modelStep(r, y, g, b);
    #1;
    compareAll(tag);
  endtask

  // Hold one light colour for n cycles. The button is either random or a
  // two-cycle press starting at cycle pressAt (negative means no press).
  task automatic runPhase(input string tag, input logic r, input logic y, input logic g,
                          input int n, input int pressAt, input bit rnd);
    logic b;
    for (int i = 0; i < n; i++) begin
      if (rnd) b = ($urandom_range(0, 7) == 0);
      else     b = (pressAt >= 0) && (i == pressAt || i == pressAt + 1);
      applyStimulus(tag, r, y, g, b);
    end
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock.
  task automatic doReset();
    @(negedge clk);
    n_reset  = 1'b0;
    red_in   = 1'b0;
    yel_in   = 1'b0;
    green_in = 1'b1;
    ped_btn  = 1'b0;
    #2;
    modelReset();
    compareAll("reset");
    @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  initial begin
    modelReset();
    #1;
    doReset();

    // Idle green, no presses.
    runPhase("idle", 1'b0, 1'b0, 1'b1, 40, -1, 1'b0);

    // Press in green, full crossing at the next red.
    runPhase("greenPress", 1'b0, 1'b0, 1'b1, 10, 2, 1'b0);
    checkOutput("latched", 32'(ped_waiting), 32'd1);
    runPhase("yel1", 1'b0, 1'b1, 1'b0, 3, -1, 1'b0);
    runPhase("onset", 1'b1, 1'b0, 1'b0, 1, -1, 1'b0);
    checkOutput("onsetCount", 32'(countdown), 32'(WT + FT));
    runPhase("cross", 1'b1, 1'b0, 1'b0, 29, -1, 1'b0);

    // Late press: no walk this red, served at the next one.
    runPhase("g2", 1'b0, 1'b0, 1'b1, 5, -1, 1'b0);
    runPhase("y2", 1'b0, 1'b1, 1'b0, 3, -1, 1'b0);
    runPhase("latePress", 1'b1, 1'b0, 1'b0, 30, 5, 1'b0);
    runPhase("g3", 1'b0, 1'b0, 1'b1, 10, -1, 1'b0);
    runPhase("y3", 1'b0, 1'b1, 1'b0, 3, -1, 1'b0);
    runPhase("lateServed", 1'b1, 1'b0, 1'b0, 30, -1, 1'b0);

    // Short red aborts the crossing.
    runPhase("g4", 1'b0, 1'b0, 1'b1, 5, 0, 1'b0);
    runPhase("y4", 1'b0, 1'b1, 1'b0, 3, -1, 1'b0);
    runPhase("shortRed", 1'b1, 1'b0, 1'b0, 12, -1, 1'b0);
    runPhase("abort", 1'b0, 1'b0, 1'b1, 1, -1, 1'b0);
    checkOutput("abortCount", 32'(countdown), 32'd0);
    runPhase("g5", 1'b0, 1'b0, 1'b1, 5, -1, 1'b0);

    // Press in WALK is ignored, press in FLASH is kept for the next red.
    runPhase("g6", 1'b0, 1'b0, 1'b1, 5, 0, 1'b0);
    runPhase("y6", 1'b0, 1'b1, 1'b0, 3, -1, 1'b0);
    runPhase("walkPress", 1'b1, 1'b0, 1'b0, 10, 5, 1'b0);
    runPhase("flashPress", 1'b1, 1'b0, 1'b0, 20, 11, 1'b0);
    runPhase("g7", 1'b0, 1'b0, 1'b1, 5, -1, 1'b0);
    runPhase("y7", 1'b0, 1'b1, 1'b0, 3, -1, 1'b0);
    runPhase("flashServed", 1'b1, 1'b0, 1'b0, 30, -1, 1'b0);

    // Illegal light combination mid-WALK locks into FAULT until reset.
    runPhase("g8", 1'b0, 1'b0, 1'b1, 5, 0, 1'b0);
    runPhase("y8", 1'b0, 1'b1, 1'b0, 3, -1, 1'b0);
    runPhase("preFault", 1'b1, 1'b0, 1'b0, 5, -1, 1'b0);
    applyStimulus("fault", 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("faultFlag", 32'(fault), 32'd1);
    runPhase("faultHold", 1'b1, 1'b0, 1'b0, 10, 2, 1'b0);
    runPhase("faultHoldG", 1'b0, 1'b0, 1'b1, 5, -1, 1'b0);
    doReset();
    runPhase("postReset", 1'b0, 1'b0, 1'b1, 5, -1, 1'b0);

    // Randomized traffic-light cycles with random button activity.
    for (int c = 0; c < 25; c++) begin
      runPhase("rndG", 1'b0, 1'b0, 1'b1, $urandom_range(5, 20), -1, 1'b1);
      runPhase("rndY", 1'b0, 1'b1, 1'b0, $urandom_range(2, 4), -1, 1'b1);
      runPhase("rndR", 1'b1, 1'b0, 1'b0, $urandom_range(8, 35), -1, 1'b1);
    end

    // Reset asserted mid-crossing.
    runPhase("g9", 1'b0, 1'b0, 1'b1, 5, 0, 1'b0);
    runPhase("y9", 1'b0, 1'b1, 1'b0, 3, -1, 1'b0);
    runPhase("midCross", 1'b1, 1'b0, 1'b0, 7, -1, 1'b0);
    doReset();
    runPhase("end", 1'b0, 1'b0, 1'b1, 5, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
